// File: rtl/prog_launcher_pkg.sv
// Shared types and constants for the program launcher block.
// Also provides the counter-width check used by prog_launcher.
package prog_launcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CRST = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } launch_state_t;

  localparam int STATS_W = 16;

  // Smallest counter width that can hold the value 'timeout' without wrapping.
  function automatic int min_cw(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  function automatic bit cw_ok(input int cw, input int timeout);
    return (cw >= min_cw(timeout));
  endfunction

endpackage

// File: rtl/prog_launcher_if.sv
// Launcher-to-core start handshake: program select, core reset, request and done.
interface prog_launcher_if #(
  parameter int PW = 2
);

  logic [PW-1:0] core_sel;
  logic          core_reset;
  logic          core_req;
  logic          core_done;

  modport master (
    output core_sel,
    output core_reset,
    output core_req,
    input  core_done
  );

  modport slave (
    input  core_sel,
    input  core_reset,
    input  core_req,
    output core_done
  );

endinterface

// File: rtl/prog_launcher_run_timer.sv
// Execution-cycle counter with clear, enable and a flag raised at count == TIMEOUT.
module prog_launcher_run_timer #(
  parameter int CW      = 13,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          at_term
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Clear wins over enable.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign at_term = (count_q == CW'(TIMEOUT));

endmodule

// File: rtl/prog_launcher.sv
// Host-side launcher for the core req/done handshake: reset hold, request, run timing, timeout.
// Optional statistics outputs (run_count, max_cycles) are enabled by defining LAUNCHER_STATS_EN.
module prog_launcher
  import prog_launcher_pkg::*;
#(
  parameter int PW      = 2,
  parameter int RST_CYC = 2,
  parameter int TIMEOUT = 4096,
  parameter int CW      = 13
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [PW-1:0] prog_sel,
  output logic          busy,
  output logic          result_valid,
  output logic [CW-1:0] cycles,
  output logic          timed_out,
  prog_launcher_if.master core
`ifdef LAUNCHER_STATS_EN
  ,
  output logic [STATS_W-1:0] run_count,
  output logic [CW-1:0]      max_cycles
`endif
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CRST = CRST;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_FIN  = FIN;
  localparam int         RW      = $clog2(RST_CYC + 1);

  if (!cw_ok(CW, TIMEOUT)) begin : g_cw_check
    $error("prog_launcher: CW too small to hold TIMEOUT");
  end

  logic [1:0]    state_q,   state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [PW-1:0] sel_q,     sel_d;
  logic [CW-1:0] cycles_q,  cycles_d;
  logic          to_q,      to_d;
  logic          busy_q,    busy_d;
  logic          rv_q,      rv_d;

  logic [CW-1:0] run_cnt;
  logic          run_term;
  logic          tmr_clr;
  logic          tmr_en;

  // Counter reads 1 in the first RUN cycle because it steps on the CRST->RUN edge.
  assign tmr_clr = (state_q == ST_IDLE);
  assign tmr_en  = (state_d == ST_RUN);

  prog_launcher_run_timer #(
    .CW      (CW),
    .TIMEOUT (TIMEOUT)
  ) u_run_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .count   (run_cnt),
    .at_term (run_term)
  );

  // Next-state and result capture; done takes priority over timeout.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    sel_d     = sel_q;
    cycles_d  = cycles_q;
    to_d      = to_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_CRST;
          sel_d     = prog_sel;
          rst_cnt_d = '0;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_CRST: begin
        if (rst_cnt_q == RW'(RST_CYC - 1)) begin
          state_d   = ST_RUN;
          rst_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end
      ST_RUN: begin
        if (core.core_done) begin
          state_d  = ST_FIN;
          cycles_d = run_cnt;
          to_d     = 1'b0;
        end else if (run_term) begin
          state_d  = ST_FIN;
          cycles_d = CW'(TIMEOUT);
          to_d     = 1'b1;
        end else begin
          state_d  = ST_RUN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs are registered so they line up with the state they describe.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    rv_d   = (state_d == ST_FIN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      rst_cnt_q <= '0;
      sel_q     <= '0;
      cycles_q  <= '0;
      to_q      <= 1'b0;
      busy_q    <= 1'b0;
      rv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      sel_q     <= sel_d;
      cycles_q  <= cycles_d;
      to_q      <= to_d;
      busy_q    <= busy_d;
      rv_q      <= rv_d;
    end
  end

`ifdef LAUNCHER_STATS_EN
  logic [STATS_W-1:0] run_count_q, run_count_d;
  logic [CW-1:0]      max_cycles_q, max_cycles_d;

  // Run count saturates; max_cycles tracks only runs that finished on done.
  always_comb begin
    run_count_d  = run_count_q;
    max_cycles_d = max_cycles_q;
    if (state_d == ST_FIN) begin
      if (run_count_q != {STATS_W{1'b1}}) begin
        run_count_d = run_count_q + STATS_W'(1);
      end else begin
        run_count_d = run_count_q;
      end
      if (!to_d && (cycles_d > max_cycles_q)) begin
        max_cycles_d = cycles_d;
      end else begin
        max_cycles_d = max_cycles_q;
      end
    end else begin
      run_count_d  = run_count_q;
      max_cycles_d = max_cycles_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      run_count_q  <= '0;
      max_cycles_q <= '0;
    end else begin
      run_count_q  <= run_count_d;
      max_cycles_q <= max_cycles_d;
    end
  end

  assign run_count  = run_count_q;
  assign max_cycles = max_cycles_q;
`endif

  assign busy            = busy_q;
  assign result_valid    = rv_q;
  assign cycles          = cycles_q;
  assign timed_out       = to_q;
  assign core.core_sel   = sel_q;
  assign core.core_reset = (state_q != ST_RUN);
  assign core.core_req   = (state_q == ST_RUN);

endmodule
